// File: rtl/bram_initiator_pkg.sv
// Shared types and constants for the buffer register initiator.
// Response entries carry {we, data}. Pipeline tokens carry {valid, we}.
package bram_initiator_pkg;

  localparam int BRAM_DW     = 32;
  localparam int BRAM_STBW   = 4;
  localparam int BRAM_RD_LAT = 2;  // ren -> slave registered rdata, in cycles

  typedef struct packed {
    logic               we;
    logic [BRAM_DW-1:0] data;
  } rsp_t;

  typedef struct packed {
    logic valid;
    logic we;
  } token_t;

  // Number of live tokens among the three in-flight stages.
  function automatic logic [1:0] token_count(token_t t1, token_t t2, token_t t3);
    return {1'b0, t1.valid} + {1'b0, t2.valid} + {1'b0, t3.valid};
  endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// In-order response FIFO, DEPTH entries of rsp_t.
// The head entry is driven straight from storage, so it holds steady while it waits to be popped.
// A push and a pop in the same cycle leave the count unchanged.
module bram_rsp_fifo
  import bram_initiator_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  rsp_t             push_data,
  input  logic             pop,
  output logic             valid,
  output rsp_t             head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  rsp_t             mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             empty_s;
  logic             full_s;
  logic             do_push_s;
  logic             do_pop_s;

  // Full and empty flags, plus the push and pop that actually take effect.
  always_comb begin
    empty_s   = (count_r == {CNT_W{1'b0}});
    full_s    = (count_r == CNT_W'(DEPTH));
    do_pop_s  = pop & ~empty_s;
    do_push_s = push & (~full_s | do_pop_s);
  end

  // Storage, pointers and occupancy count. Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {($bits(rsp_t)){1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign valid = ~empty_s;
  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/bram_reg_initiator.sv
// Buffer register interface initiator.
// It turns an in-order request stream into registered bram_wen, bram_ren and bram_regen cycles.
// Responses return in request order through bram_rsp_fifo.
// Write acknowledgements are produced only when BRAM_INITIATOR_WACK_EN is defined.
module bram_reg_initiator
  import bram_initiator_pkg::*;
#(
  parameter int RSP_DEPTH = 4,
  parameter int ADDR_W    = 8
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_we,
  output logic [31:0]       bram_waddr,
  output logic [31:0]       bram_wdata,
  output logic [3:0]        bram_wstb,
  output logic              bram_wen,
  output logic [31:0]       bram_raddr,
  output logic              bram_ren,
  output logic              bram_regen,
  input  logic [31:0]       bram_rdata
);

`ifdef BRAM_INITIATOR_WACK_EN
  localparam logic WACK_EN = 1'b1;
`else
  localparam logic WACK_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  logic                 ready_en_r;
  logic                 wen_r;
  logic                 ren_r;
  logic                 regen_r;
  logic [31:0]          waddr_r;
  logic [31:0]          wdata_r;
  logic [BRAM_STBW-1:0] wstb_r;
  logic [31:0]          raddr_r;
  token_t               tok1_r;
  token_t               tok2_r;
  token_t               tok3_r;
  token_t               tok_in_s;
  logic                 accept_s;
  logic                 credit_ok_s;
  logic [OCC_W-1:0]     occupancy_s;
  logic [CNT_W-1:0]     fifo_count_s;
  rsp_t                 push_data_s;
  rsp_t                 head_s;

  // Handshake, the new token, and the credit check.
  // Credit uses only registered FIFO and pipe occupancy.
  always_comb begin
    accept_s       = req_valid & req_ready;
    tok_in_s.valid = accept_s & (~req_we | WACK_EN);
    tok_in_s.we    = req_we;
    occupancy_s    = {1'b0, fifo_count_s} + OCC_W'(token_count(tok1_r, tok2_r, tok3_r));
    credit_ok_s    = (occupancy_s < OCC_W'(RSP_DEPTH));
    req_ready      = ready_en_r & credit_ok_s;
  end

  // Issue stage: one registered strobe cycle per accepted request.
  // Address and data hold their last value while the strobes are low.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en_r <= 1'b0;
      wen_r      <= 1'b0;
      ren_r      <= 1'b0;
      waddr_r    <= 32'h0;
      wdata_r    <= 32'h0;
      wstb_r     <= {BRAM_STBW{1'b0}};
      raddr_r    <= 32'h0;
    end else begin
      ready_en_r <= 1'b1;
      wen_r      <= accept_s & req_we;
      ren_r      <= accept_s & ~req_we;
      if (accept_s & req_we) begin
        waddr_r <= {{(32-ADDR_W){1'b0}}, req_addr};
        wdata_r <= req_wdata;
        wstb_r  <= req_wstb;
      end
      if (accept_s & ~req_we) begin
        raddr_r <= {{(32-ADDR_W){1'b0}}, req_addr};
      end
    end
  end

  // Token pipe. tok1 is the issue cycle and tok2 is the regen cycle.
  // tok3 is the cycle in which the slave's registered data is pushed.
  // Clearing it on reset drops any read still in flight.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      tok1_r  <= 2'b00;
      tok2_r  <= 2'b00;
      tok3_r  <= 2'b00;
      regen_r <= 1'b0;
    end else begin
      tok1_r  <= tok_in_s;
      tok2_r  <= tok1_r;
      tok3_r  <= tok2_r;
      regen_r <= tok1_r.valid & ~tok1_r.we;
    end
  end

  // Read tokens push the slave data. Write acknowledgements push zero.
  always_comb begin
    push_data_s.we = tok3_r.we;
    if (tok3_r.we) begin
      push_data_s.data = 32'h0;
    end else begin
      push_data_s.data = bram_rdata;
    end
  end

  bram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .push      (tok3_r.valid),
    .push_data (push_data_s),
    .pop       (rsp_ready),
    .valid     (rsp_valid),
    .head      (head_s),
    .count     (fifo_count_s)
  );

  assign rsp_data   = head_s.data;
  assign rsp_we     = head_s.we;
  assign bram_waddr = waddr_r;
  assign bram_wdata = wdata_r;
  assign bram_wstb  = wstb_r;
  assign bram_wen   = wen_r;
  assign bram_raddr = raddr_r;
  assign bram_ren   = ren_r;
  assign bram_regen = regen_r;

endmodule

// File: tb/tb_bram_reg_initiator.sv
// Self-checking bench for bram_reg_initiator.
// It contains a registered-read slave model and a queue-based reference of expected responses.
// It also runs directed table vectors, hand-written corner sequences and a randomized phase.
// Honours BRAM_INITIATOR_WACK_EN in the same way as the design.
module tb_bram_reg_initiator;

  localparam int DEPTH = 4;
`ifdef BRAM_INITIATOR_WACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = 8'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_wstb = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_we;
  logic [31:0] bram_waddr, bram_wdata, bram_raddr, bram_rdata;
  logic [3:0]  bram_wstb;
  logic        bram_wen, bram_ren, bram_regen;

  always #5 ACLK = ~ACLK;

  bram_reg_initiator #(.RSP_DEPTH(DEPTH), .ADDR_W(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstb(req_wstb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_we(rsp_we),
    .bram_waddr(bram_waddr), .bram_wdata(bram_wdata), .bram_wstb(bram_wstb), .bram_wen(bram_wen),
    .bram_raddr(bram_raddr), .bram_ren(bram_ren), .bram_regen(bram_regen), .bram_rdata(bram_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    return 32'h1000_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Slave: updates on the write edge, captures the address on ren, registers data on regen.
  logic [31:0] smem [256];
  logic [7:0]  s_addr_q;
  logic [31:0] s_rdata;
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 256; i++) smem[i] <= init_word(i);
      s_addr_q <= 8'h0;
      s_rdata  <= 32'h0;
    end else begin
      if (bram_wen) smem[bram_waddr[7:0]] <= merge(smem[bram_waddr[7:0]], bram_wdata, bram_wstb);
      if (bram_ren) s_addr_q <= bram_raddr[7:0];
      if (bram_regen) s_rdata <= smem[s_addr_q];
    end
  end
  assign bram_rdata = s_rdata;

  // Reference model: memory image plus a queue of responses owed, in request order.
  typedef struct { bit we; bit [31:0] data; } rsp_e;
  rsp_e        exp_q[$];
  logic [31:0] ref_mem [256];
  bit          exp_wen, exp_ren, exp_regen;
  logic [7:0]  exp_addr;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_wstb;
  int          total = 0, bad = 0;
  int          acc_cnt = 0, ren_cnt = 0, pop_cnt = 0;
  logic [31:0] pop_data_log[$];
  bit          pop_we_log[$];

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstb;
    logic [31:0] exp_data;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    exp_wen = 1'b0; exp_ren = 1'b0; exp_regen = 1'b0;
  endtask

  // One cycle: check outputs against the model, account for handshakes, advance to the next negedge.
  task automatic step();
    bit   acc, pop;
    rsp_e e;
    chk("bram_wen", bram_wen, exp_wen);
    chk("bram_ren", bram_ren, exp_ren);
    chk("bram_regen", bram_regen, exp_regen);
    if (bram_ren === 1'b1) ren_cnt++;
    if (exp_wen) begin
      chk("bram_waddr", bram_waddr, {24'h0, exp_addr});
      chk("bram_wdata", bram_wdata, exp_wdata);
      chk("bram_wstb", bram_wstb, exp_wstb);
    end
    if (exp_ren) chk("bram_raddr", bram_raddr, {24'h0, exp_addr});
    chk("req_ready", req_ready, (exp_q.size() < DEPTH));
    acc = (req_valid === 1'b1) && (req_ready === 1'b1);
    pop = (rsp_valid === 1'b1) && (rsp_ready === 1'b1);
    if (pop) begin
      if (exp_q.size() == 0) begin
        chk("rsp_spurious", rsp_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_we", rsp_we, e.we);
        chk("rsp_data", rsp_data, e.data);
        pop_data_log.push_back(rsp_data);
        pop_we_log.push_back(rsp_we);
        pop_cnt++;
      end
    end
    exp_regen = exp_ren;
    exp_wen   = acc && req_we;
    exp_ren   = acc && !req_we;
    if (acc) begin
      acc_cnt++;
      exp_addr = req_addr; exp_wdata = req_wdata; exp_wstb = req_wstb;
      if (req_we) begin
        ref_mem[req_addr] = merge(ref_mem[req_addr], req_wdata, req_wstb);
        if (WACK) exp_q.push_back('{1'b1, 32'h0});
      end else begin
        exp_q.push_back('{1'b0, ref_mem[req_addr]});
      end
    end
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic send(bit we, logic [7:0] a, logic [31:0] d, logic [3:0] s);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstb = s;
    while (req_ready !== 1'b1 && n < 20) begin step(); n++; end
    chk("send_ready", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 30) begin step(); n++; end
    lat = n;
    chk("rsp_timeout", rsp_valid, 1'b1);
    step();
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0; rsp_ready = 1'b1;
    while (exp_q.size() > 0 && n < 80) begin step(); n++; end
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_rsp_valid", rsp_valid, 1'b0);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_data"}, rsp_data, 32'h0);
    chk({tag, "_rsp_we"}, rsp_we, 1'b0);
    chk({tag, "_wen"}, bram_wen, 1'b0);
    chk({tag, "_ren"}, bram_ren, 1'b0);
    chk({tag, "_regen"}, bram_regen, 1'b0);
    chk({tag, "_waddr"}, bram_waddr, 32'h0);
    chk({tag, "_wdata"}, bram_wdata, 32'h0);
    chk({tag, "_wstb"}, bram_wstb, 4'h0);
    chk({tag, "_raddr"}, bram_raddr, 32'h0);
  endtask

  initial begin
    int lat, k, n, a0, r0, p0, c4;
    logic [31:0] rd_vals[$];

    tbl[0] = '{1'b1, 8'hf0, 32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1] = '{1'b0, 8'hf0, 32'h0,        4'h0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 8'h10, 32'h00000001, 4'hF, 32'h0};
    tbl[3] = '{1'b0, 8'h10, 32'h0,        4'h0, 32'h00000001};
    tbl[4] = '{1'b1, 8'h10, 32'h00000002, 4'hF, 32'h0};
    tbl[5] = '{1'b0, 8'h10, 32'h0,        4'h0, 32'h00000002};
    tbl[6] = '{1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, 32'h0};
    tbl[7] = '{1'b0, 8'h20, 32'h0,        4'h0, 32'h10BB00DD};

    // Reset state
    model_clear();
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    chk_reset_outputs("reset");
    ARESETN = 1'b1;
    @(posedge ACLK); @(negedge ACLK);

    // Directed table: writes, reads-after-write, strobes, latency accept -> rsp_valid
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].wstb);
      if (!tbl[i].we || WACK) begin
        wait_rsp(lat);
        chk("tbl_latency", lat, 3);
        chk("tbl_rsp_we", pop_we_log[pop_we_log.size()-1], tbl[i].we);
        chk("tbl_rsp_data", pop_data_log[pop_data_log.size()-1], tbl[i].exp_data);
      end else begin
        repeat (4) step();
      end
    end

    // 8 back-to-back reads with rsp_ready held high
    a0 = acc_cnt; r0 = ren_cnt; p0 = pop_cnt; k = 0; n = 0; c4 = 0;
    while (k < 8 && n < 60) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h40 + 8'(k);
      step(); n++;
      if (acc_cnt != a0 + k) k++;
      if (k == 4 && c4 == 0) c4 = n;
    end
    drain();
    chk("b2b_accepts", acc_cnt - a0, 8);
    chk("b2b_first4_cycles", c4, 4);
    chk("b2b_ren", ren_cnt - r0, 8);
    chk("b2b_rsps", pop_cnt - p0, 8);

    // Credit limit with a stalled response side
    rsp_ready = 1'b0;
    a0 = acc_cnt; r0 = ren_cnt; p0 = pop_cnt; k = 0;
    for (int c = 0; c < 12; c++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h50 + 8'(k);
      step();
      if (acc_cnt != a0 + k) k++;
    end
    chk("credit_accepts", acc_cnt - a0, 4);
    chk("credit_ren", ren_cnt - r0, 4);
    chk("credit_ready_low", req_ready, 1'b0);
    chk("credit_rsp_valid", rsp_valid, 1'b1);
    rsp_ready = 1'b1; n = 0;
    while (k < 6 && n < 40) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h50 + 8'(k);
      step(); n++;
      if (acc_cnt != a0 + k) k++;
    end
    drain();
    chk("credit_total_accepts", acc_cnt - a0, 6);
    chk("credit_total_ren", ren_cnt - r0, 6);
    chk("credit_total_rsps", pop_cnt - p0, 6);

    // Back-to-back write/read/write/read to one address
    pop_data_log.delete(); pop_we_log.delete();
    a0 = acc_cnt; k = 0; n = 0;
    while (k < 4 && n < 40) begin
      req_valid = 1'b1; req_addr = 8'h30; req_wstb = 4'hF;
      req_we    = (k % 2 == 0);
      req_wdata = (k < 2) ? 32'h1 : 32'h2;
      step(); n++;
      if (acc_cnt != a0 + k) k++;
    end
    drain();
    rd_vals.delete();
    for (int i = 0; i < pop_data_log.size(); i++) if (!pop_we_log[i]) rd_vals.push_back(pop_data_log[i]);
    chk("mix_read_count", rd_vals.size(), 2);
    if (rd_vals.size() == 2) begin
      chk("mix_read0", rd_vals[0], 32'h1);
      chk("mix_read1", rd_vals[1], 32'h2);
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom_range(0, 15));
      req_wdata = $urandom;
      req_wstb  = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // Reset while a read is between ren and the push
    send(1'b0, 8'h60, 32'h0, 4'h0);
    step();
    ARESETN = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_clear();
    @(negedge ACLK); @(negedge ACLK);
    chk_reset_outputs("heldreset");
    ARESETN = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("post_reset_rsp_valid", rsp_valid, 1'b0);
      step();
    end
    send(1'b0, 8'h61, 32'h0, 4'h0);
    wait_rsp(lat);
    chk("post_reset_read_latency", lat, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
